// File: rtl/i2c_pkg.sv
// Shared I2C target types: FSM state encoding and bus timing limits.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } i2c_state_e;

  // CLK must run at least this many times faster than SCL.
  localparam int MIN_CLK_PER_SCL = 16;
  localparam int BIT_CNT_W       = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// 2-flop synchroniser for one bus line with rise/fall flags on the synchronised value.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchronise; [2] holds the previous synchronised value for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], line_i};
  end

  assign line_o = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer and strobe-based register access.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] WR_DATA,
  output logic       WR_STB,
  output logic       RD_STB,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk_i(CLK), .rst_n_i(RESET_N), .line_i(I2C_SCL),
    .line_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i(CLK), .rst_n_i(RESET_N), .line_i(I2C_SDA),
    .line_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e           state_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [7:0]           shift_q, reg_addr_q, wr_data_q;
  logic                 sda_oe_q, wr_stb_q, rd_stb_q, busy_q;
  logic                 first_q, rw_q, inc_q, rd_pend_q;

  logic       start, stop;
  logic [7:0] byte_d;

  assign start  = sda_fall & scl_s;
  assign stop   = sda_rise & scl_s;
  assign byte_d = {shift_q[6:0], sda_s};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= 8'h00;
      reg_addr_q <= 8'h00;
      wr_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      inc_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= rd_pend_q;
      rd_pend_q <= 1'b0;
      inc_q     <= 1'b0;
      // Post-write pointer bump lands one CLK after WR_STB.
      if (inc_q) reg_addr_q <= reg_addr_q + 8'd1;

      if (start) begin
        state_q  <= ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
        first_q  <= 1'b1;
      end else if (stop) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 1'b1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_q  <= ADDR_ACK;
                sda_oe_q <= 1'b1;
                rw_q     <= shift_q[0];
              end else begin
                state_q  <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise && rw_q) begin
              rd_stb_q <= 1'b1;
            end else if (scl_fall) begin
              cnt_q <= '0;
              if (rw_q) begin
                state_q  <= RD_BYTE;
                shift_q  <= RD_DATA;
                sda_oe_q <= ~RD_DATA[7];
              end else begin
                state_q  <= WR_BYTE;
                sda_oe_q <= 1'b0;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == 4'd7) begin
                // First byte after the address is the register pointer.
                if (first_q) begin
                  reg_addr_q <= byte_d;
                  first_q    <= 1'b0;
                end else begin
                  wr_data_q <= byte_d;
                  wr_stb_q  <= 1'b1;
                  inc_q     <= 1'b1;
                end
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              state_q  <= WR_ACK;
              sda_oe_q <= 1'b1;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state_q  <= WR_BYTE;
              sda_oe_q <= 1'b0;
              cnt_q    <= '0;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                state_q  <= RD_ACK;
                sda_oe_q <= 1'b0;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                reg_addr_q <= reg_addr_q + 8'd1;
                rd_pend_q  <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end else if (scl_fall) begin
              state_q  <= RD_BYTE;
              shift_q  <= RD_DATA;
              sda_oe_q <= ~RD_DATA[7];
              cnt_q    <= '0;
            end
          end
          IGNORE:  sda_oe_q <= 1'b0;
          default: state_q  <= IDLE;
        endcase
      end
    end
  end

  assign I2C_SDA  = sda_oe_q ? 1'b0 : 1'bz;
  assign REG_ADDR = reg_addr_q;
  assign WR_DATA  = wr_data_q;
  assign WR_STB   = wr_stb_q;
  assign RD_STB   = rd_stb_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged initiator, strobe scoreboard, write-vector table.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = MIN_CLK_PER_SCL / 4 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       tb_sda_oe = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] reg_addr, wr_data;
  logic       wr_stb, rd_stb, busy;
  wire        sda;

  pullup (sda);
  assign sda = tb_sda_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50)) dut (
    .CLK(clk), .RESET_N(rst_n), .I2C_SCL(scl), .I2C_SDA(sda),
    .REG_ADDR(reg_addr), .WR_DATA(wr_data), .WR_STB(wr_stb), .RD_STB(rd_stb),
    .RD_DATA(rd_data), .BUSY(busy)
  );

  int checks = 0;
  int failures = 0;
  int dut_low = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  typedef struct packed { logic is_wr; logic [7:0] addr; logic [7:0] data; } ev_t;
  ev_t exp_q[$];

  task automatic push_ev(input logic is_wr, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = is_wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Strobe scoreboard plus the user-side register file for reads.
  always @(negedge clk) begin
    if (rst_n && (wr_stb || rd_stb)) begin
      ev_t e;
      if (wr_stb && rd_stb) chk("stb_overlap", {wr_stb, rd_stb}, 2'b10);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_stb: got wr=%0b rd=%0b addr=%0h expected none", wr_stb, rd_stb, reg_addr);
      end else begin
        e = exp_q.pop_front();
        chk("stb_kind", {31'd0, wr_stb}, {31'd0, e.is_wr});
        chk("stb_addr", {24'd0, reg_addr}, {24'd0, e.addr});
        if (e.is_wr) chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
      if (rd_stb) rd_data = rd_val(reg_addr);
    end
  end

  always @(negedge clk) if (!tb_sda_oe && sda == 1'b0) dut_low++;

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    tb_sda_oe = 1'b0; wq(); scl = 1'b1; wq(); tb_sda_oe = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    tb_sda_oe = 1'b1; wq(); scl = 1'b1; wq(); tb_sda_oe = 1'b0; wq(2);
  endtask

  task automatic wbit(input logic b);
    tb_sda_oe = !b; wq(); scl = 1'b1; wq(2); scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    tb_sda_oe = 1'b0; wq(); scl = 1'b1; wq(); b = sda; wq(); scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = !b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(!ack);
  endtask

  typedef struct {
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] exp_addr;
  } wvec_t;

  initial begin
    wvec_t      tv[3];
    logic       ack;
    logic [7:0] rb, a;

    tv[0] = '{8'h10, 2, 8'h55, 8'hAA, 8'h12};
    tv[1] = '{8'hFF, 2, 8'h3C, 8'hC3, 8'h01};
    tv[2] = '{8'h33, 0, 8'h00, 8'h00, 8'h33};

    repeat (4) @(negedge clk);
    chk("rst_sda", {31'd0, sda}, 1);
    chk("rst_reg_addr", {24'd0, reg_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk("rst_strobes", {30'd0, wr_stb, rd_stb}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    wq(2);

    // Table-driven write transactions.
    for (int v = 0; v < 3; v++) begin
      bus_start();
      write_byte(8'hA0, ack); chk("wr_addr_ack", {31'd0, ack}, 1);
      write_byte(tv[v].ptr, ack); chk("wr_ptr_ack", {31'd0, ack}, 1);
      for (int j = 0; j < tv[v].n; j++) begin
        a = tv[v].ptr + 8'(j);
        rb = (j == 0) ? tv[v].d0 : tv[v].d1;
        push_ev(1'b1, a, rb);
        write_byte(rb, ack); chk("wr_data_ack", {31'd0, ack}, 1);
      end
      bus_stop();
      chk("wr_final_addr", {24'd0, reg_addr}, {24'd0, tv[v].exp_addr});
      chk("wr_busy_after_stop", {31'd0, busy}, 0);
      chk("wr_sb_drained", exp_q.size(), 0);
    end

    // Pointer write, repeated START, read two bytes (ACK then NACK).
    bus_start();
    write_byte(8'hA0, ack); chk("rd_addr_w_ack", {31'd0, ack}, 1);
    write_byte(8'h20, ack); chk("rd_ptr_ack", {31'd0, ack}, 1);
    bus_start();
    push_ev(1'b0, 8'h20, 8'h00);
    push_ev(1'b0, 8'h21, 8'h00);
    write_byte(8'hA1, ack); chk("rd_addr_r_ack", {31'd0, ack}, 1);
    read_byte(rb, 1'b1); chk("rd_byte0", {24'd0, rb}, {24'd0, rd_val(8'h20)});
    read_byte(rb, 1'b0); chk("rd_byte1", {24'd0, rb}, {24'd0, rd_val(8'h21)});
    chk("rd_sda_released_after_nack", {31'd0, sda}, 1);
    bus_stop();
    chk("rd_final_addr", {24'd0, reg_addr}, 8'h21);

    // Read with no pointer write continues from the last pointer.
    bus_start();
    push_ev(1'b0, 8'h21, 8'h00);
    write_byte(8'hA1, ack); chk("cont_addr_ack", {31'd0, ack}, 1);
    read_byte(rb, 1'b0); chk("cont_byte", {24'd0, rb}, {24'd0, rd_val(8'h21)});
    bus_stop();

    // Foreign address: never ACKed, SDA never driven, BUSY spans START..STOP.
    dut_low = 0;
    bus_start();
    write_byte(8'hA2, ack); chk("foreign_addr_nack", {31'd0, ack}, 0);
    write_byte(8'h12, ack); chk("foreign_data_nack", {31'd0, ack}, 0);
    chk("foreign_busy", {31'd0, busy}, 1);
    bus_stop();
    chk("foreign_busy_after_stop", {31'd0, busy}, 0);
    chk("foreign_sda_driven", dut_low, 0);
    chk("foreign_reg_addr", {24'd0, reg_addr}, 8'h21);

    // STOP after 4 data bits: no strobe, then a normal write.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack); chk("midstop_ptr_ack", {31'd0, ack}, 1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    bus_stop();
    chk("midstop_busy", {31'd0, busy}, 0);
    chk("midstop_reg_addr", {24'd0, reg_addr}, 8'h40);
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    push_ev(1'b1, 8'h40, 8'h77);
    write_byte(8'h77, ack); chk("midstop_next_ack", {31'd0, ack}, 1);
    bus_stop();
    chk("midstop_next_addr", {24'd0, reg_addr}, 8'h41);

    // Reset while the target drives a 0 read bit.
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    bus_start();
    push_ev(1'b0, 8'h30, 8'h00);
    write_byte(8'hA1, ack); chk("rst_rd_addr_ack", {31'd0, ack}, 1);
    chk("rst_rd_bit_driven", {31'd0, sda}, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sda", {31'd0, sda}, 1);
    chk("rst_mid_reg_addr", {24'd0, reg_addr}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_strobes", {30'd0, wr_stb, rd_stb}, 0);
    scl = 1'b1;
    wq();
    rst_n = 1'b1;
    wq(2);

    // Bits without a START must be ignored.
    dut_low = 0;
    scl = 1'b0; wq();
    for (int i = 7; i >= 0; i--) wbit(1'(8'hA0 >> i));
    rbit(ack);
    tb_sda_oe = 1'b0; scl = 1'b1; wq(2);
    chk("post_rst_no_ack", dut_low, 0);
    chk("post_rst_busy", {31'd0, busy}, 0);

    bus_start();
    write_byte(8'hA0, ack); chk("post_rst_addr_ack", {31'd0, ack}, 1);
    write_byte(8'h05, ack);
    push_ev(1'b1, 8'h05, 8'h99);
    write_byte(8'h99, ack);
    bus_stop();
    chk("post_rst_addr", {24'd0, reg_addr}, 8'h06);

    wq(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, 7-bit bus address the block responds to.
REQ-002 CLK  input  1  system clock; all state on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 I2C_SCL  input  1  bus clock from the initiator; the block never stretches it.
REQ-005 I2C_SDA  inout  1  bus data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-006 REG_ADDR  output  8  current register pointer.
REQ-007 WR_DATA  output  8  byte received for REG_ADDR.
REQ-008 WR_STB  output  1  one-CLK pulse: WR_DATA valid for REG_ADDR.
REQ-009 RD_STB  output  1  one-CLK pulse: user shall present RD_DATA for REG_ADDR.
REQ-010 RD_DATA  input  8  read byte, valid by 2 CLK after RD_STB and held until the next RD_STB.
REQ-011 BUSY  output  1  high from a detected START to a detected STOP.

Function
REQ-012 The block shall sample SCL and SDA through 2-flop synchronisers; all edge, START and STOP detection shall use the synchronised values (pin-to-event latency 3 CLK); CLK shall be at least 16x SCL.
REQ-013 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both shall be honoured in any state, including mid-byte.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-015 START (incl. repeated START) -> ADDR with the bit counter cleared; STOP -> IDLE with SDA released.
REQ-016 Data bits shall be shifted MSB first on SCL rising edges; SDA output changes shall occur only on the CLK after a detected SCL falling edge.
REQ-017 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR -> ADDR_ACK (drive SDA low for one SCL period), otherwise -> IGNORE (SDA released until the next START/STOP).
REQ-018 After the write-direction ADDR_ACK -> WR_BYTE; the first byte of the transaction shall load REG_ADDR with no WR_STB; each later byte shall pulse WR_STB on its 8th SCL rising edge, then REG_ADDR shall increment on the following CLK.
REQ-019 WR_ACK: the block shall ACK every write byte, then return to WR_BYTE.
REQ-020 After the read-direction ADDR_ACK, RD_STB shall pulse on the SCL rising edge of the ACK bit; RD_DATA shall be latched into the shifter on the SCL falling edge that ends the ACK bit; RD_BYTE shall drive each bit (0 -> low, 1 -> released).
REQ-021 RD_ACK: SDA released; on the SCL rising edge, sampled low (ACK) -> increment REG_ADDR, pulse RD_STB one CLK later, and load the next byte on the next falling edge; sampled high (NACK) -> IGNORE.
REQ-022 REG_ADDR arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
REQ-023 REG_ADDR shall persist across transactions, so a read without a pointer write continues from the last pointer.
REQ-024 A write transaction consisting only of the pointer byte shall update REG_ADDR with no WR_STB.
REQ-025 WR_STB and RD_STB shall never be asserted in the same CLK.

Reset
REQ-026 While RESET_N is low: state IDLE, SDA released (z), REG_ADDR 8'h00, WR_DATA 8'h00, WR_STB 0, RD_STB 0, BUSY 0, synchronisers loaded to 1.
REQ-027 Reset asserted mid-transaction shall release SDA immediately (asynchronously); after release the block shall stay in IDLE until a fresh START.

Structure
REQ-028 State encoding and the minimum CLK/SCL ratio constant shall live in a shared package i2c_pkg.
REQ-029 One sub-module, i2c_line_sync (2-flop synchroniser plus rise/fall edge flags), shall be instantiated once per line.

Verification
REQ-030 Write 0xA0,0x10,0x55,0xAA, STOP -> ACK on all 4 bytes; WR_STB with (0x10,0x55) then (0x11,0xAA); REG_ADDR=0x12.
REQ-031 Write 0xA0,0x20, repeated START, 0xA1, read 2 bytes ACK then NACK, STOP -> RD_STB at 0x20 and 0x21; bus carries the RD_DATA values; SDA released after NACK.
REQ-032 Address 0xA2 (7'h51) -> no ACK, no strobes, SDA never driven, BUSY high until STOP.
REQ-033 Pointer 0xFF then write 2 bytes -> writes to 0xFF then 0x00.
REQ-034 STOP injected after bit 4 of a data byte -> state IDLE, no WR_STB; the next transaction behaves normally.
REQ-035 RESET_N low while driving a read bit low -> SDA=z within the same cycle; all outputs at reset values.
